// File: rtl/kms_pkg.sv
// Shared type codes, FSM state and mouse arithmetic for kbd_mouse_sched.
// KMS_MOUSE_SAT_EN selects signed saturation instead of 8-bit wrap for mouse updates.
package kms_pkg;

    localparam logic [1:0] KMS_MOUSE_X = 2'd0;
    localparam logic [1:0] KMS_MOUSE_Y = 2'd1;
    localparam logic [1:0] KMS_KEY     = 2'd2;
    localparam logic [1:0] KMS_OSD     = 2'd3;

    typedef enum logic {IDLE, ROUTE} kms_state_t;

    function automatic logic [7:0] mouse_add(input logic [7:0] a, input logic [7:0] d);
`ifdef KMS_MOUSE_SAT_EN
        logic [8:0] s;
        s = {a[7], a} + {d[7], d};
        // sign bits disagree only when the true sum left the int8 range
        if (s[8] != s[7])
            return s[8] ? 8'h80 : 8'h7f;
        return s[7:0];
`else
        return a + d;
`endif
    endfunction

endpackage

// File: rtl/kbd_mouse_sched_if.sv
// Keycode valid/ready and OSD hold/ack handshakes toward the Amiga-side consumers.
interface kbd_mouse_sched_if;
    logic       key_valid;
    logic [7:0] key_data;
    logic       key_ready;
    logic       osd_valid;
    logic [7:0] osd_data;
    logic       osd_ack;

    modport master (output key_valid, key_data, osd_valid, osd_data,
                    input  key_ready, osd_ack);
    modport slave  (input  key_valid, key_data, osd_valid, osd_data,
                    output key_ready, osd_ack);
endinterface

// File: rtl/kms_fifo.sv
// Synchronous byte FIFO; a pop frees a slot for a same-cycle push even when full.
module kms_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/kbd_mouse_sched.sv
// Routes toggle-strobed SPI bytes to mouse counters, keycode FIFO and OSD register.
// KMS_MOUSE_SAT_EN (see kms_pkg) makes mouse_x/mouse_y saturate instead of wrap.
module kbd_mouse_sched
    import kms_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      kms_level,
    input  logic [1:0]                kms_type,
    input  logic [7:0]                kms_data,
    input  logic [2:0]                mouse_btn_in,
    kbd_mouse_sched_if.master         kio,
    output logic [7:0]                mouse_x,
    output logic [7:0]                mouse_y,
    output logic [2:0]                mouse_btn,
    output logic [AW:0]               key_count,
    output logic                      overflow,
    input  logic                      ovf_clr
);

    logic       s1, s2, s3;
    logic [1:0] warm;
    logic       evt;
    logic [2:0] btn_s1;

    kms_state_t state;
    logic [1:0] cap_type;
    logic [7:0] cap_data;
    logic       osd_valid_q;
    logic [7:0] osd_data_q;

    logic route, push, pop, fifo_full, fifo_empty;
    logic osd_load, osd_drop, key_drop;
    logic [7:0] fifo_dout;

    // A level left toggled across reset would otherwise look like a fresh edge
    // once the cleared synchronizer refills; ignore edges until it has settled.
    assign evt = (s2 ^ s3) & (warm == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            warm      <= '0;
            btn_s1    <= '0;
            mouse_btn <= '0;
        end else begin
            s1        <= kms_level;
            s2        <= s1;
            s3        <= s2;
            warm      <= warm + 2'(warm != 2'd3);
            btn_s1    <= mouse_btn_in;
            mouse_btn <= btn_s1;
        end
    end

    assign route    = (state == ROUTE);
    assign push     = route && (cap_type == KMS_KEY);
    assign pop      = kio.key_valid & kio.key_ready;
    assign key_drop = push && fifo_full && !pop;
    assign osd_load = route && (cap_type == KMS_OSD) && (!osd_valid_q || kio.osd_ack);
    assign osd_drop = route && (cap_type == KMS_OSD) && osd_valid_q && !kio.osd_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cap_type    <= '0;
            cap_data    <= '0;
            mouse_x     <= '0;
            mouse_y     <= '0;
            osd_valid_q <= 1'b0;
            osd_data_q  <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (evt) begin
                    cap_type <= kms_type;
                    cap_data <= kms_data;
                    state    <= ROUTE;
                end
                ROUTE: begin
                    case (cap_type)
                        KMS_MOUSE_X: mouse_x <= mouse_add(mouse_x, cap_data);
                        KMS_MOUSE_Y: mouse_y <= mouse_add(mouse_y, cap_data);
                        default: ;
                    endcase
                    state <= IDLE;
                end
            endcase

            if (osd_load) begin
                osd_data_q  <= cap_data;
                osd_valid_q <= 1'b1;
            end else if (kio.osd_ack) begin
                osd_valid_q <= 1'b0;
            end

            if (osd_drop || key_drop) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
        end
    end

    kms_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_key_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .din   (cap_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (key_count)
    );

    assign kio.key_valid = ~fifo_empty;
    assign kio.key_data  = fifo_dout;
    assign kio.osd_valid = osd_valid_q;
    assign kio.osd_data  = osd_data_q;

endmodule

// File: tb/tb_kbd_mouse_sched.sv
// Directed and randomized checks of kbd_mouse_sched against a queue-based reference model.
module tb_kbd_mouse_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       kms_level = 1'b0;
    logic [1:0] kms_type = '0;
    logic [7:0] kms_data = '0;
    logic [2:0] mouse_btn_in = '0;
    logic [7:0] mouse_x, mouse_y;
    logic [2:0] mouse_btn;
    logic [3:0] key_count;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    kbd_mouse_sched_if kio();

    kbd_mouse_sched #(.FIFO_DEPTH(8), .AW(3)) dut (
        .clk(clk), .reset(reset), .kms_level(kms_level), .kms_type(kms_type),
        .kms_data(kms_data), .mouse_btn_in(mouse_btn_in), .kio(kio),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_btn(mouse_btn),
        .key_count(key_count), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // reference model state
    logic [7:0] q[$];
    logic [7:0] mx, my, od;
    logic       ov, ovf;

    function automatic logic [7:0] m_add(input logic [7:0] a, input logic [7:0] d);
        int s;
        s = int'($signed(a)) + int'($signed(d));
`ifdef KMS_MOUSE_SAT_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`endif
        return 8'(s);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, 32'(key_count), 32'(q.size()));
        check({tag, ".kvalid"}, 32'(kio.key_valid), 32'(q.size() != 0));
        if (q.size() != 0) check({tag, ".kdata"}, 32'(kio.key_data), 32'(q[0]));
        check({tag, ".ovalid"}, 32'(kio.osd_valid), 32'(ov));
        check({tag, ".odata"}, 32'(kio.osd_data), 32'(od));
        check({tag, ".ovf"}, 32'(overflow), 32'(ovf));
        check({tag, ".mx"}, 32'(mouse_x), 32'(mx));
        check({tag, ".my"}, 32'(mouse_y), 32'(my));
        check({tag, ".btn"}, 32'(mouse_btn), 32'(mouse_btn_in));
    endtask

    task automatic model_byte(input logic [1:0] t, input logic [7:0] d);
        case (t)
            2'd0: mx = m_add(mx, d);
            2'd1: my = m_add(my, d);
            2'd2: if (q.size() < 8) q.push_back(d); else ovf = 1'b1;
            default: if (!ov) begin od = d; ov = 1'b1; end else ovf = 1'b1;
        endcase
    endtask

    // byte with key_ready/osd_ack idle throughout
    task automatic send(input logic [1:0] t, input logic [7:0] d);
        kms_type  = t;
        kms_data  = d;
        kms_level = ~kms_level;
        tick(6);
        model_byte(t, d);
    endtask

    // toggle, then raise one handshake input exactly in the routing cycle
    task automatic send_with(input logic [1:0] t, input logic [7:0] d, input int which);
        kms_type  = t;
        kms_data  = d;
        kms_level = ~kms_level;
        tick(3);
        if (which == 0) kio.key_ready = 1'b1;
        else if (which == 1) kio.osd_ack = 1'b1;
        else ovf_clr = 1'b1;
        tick(1);
        kio.key_ready = 1'b0;
        kio.osd_ack   = 1'b0;
        ovf_clr       = 1'b0;
        tick(3);
    endtask

    task automatic pop_one(input string tag);
        check(tag, 32'(kio.key_data), 32'(q[0]));
        kio.key_ready = 1'b1;
        tick(1);
        kio.key_ready = 1'b0;
        void'(q.pop_front());
    endtask

    task automatic ack_osd();
        kio.osd_ack = 1'b1;
        tick(1);
        kio.osd_ack = 1'b0;
        ov = 1'b0;
    endtask

    task automatic clr_ovf();
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        ovf = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(4);
        q.delete();
        mx = '0; my = '0; od = '0; ov = 1'b0; ovf = 1'b0;
    endtask

    initial begin
        int lat;
        int c0;
        kio.key_ready = 1'b0;
        kio.osd_ack   = 1'b0;
        q.delete();
        mx = '0; my = '0; od = '0; ov = 1'b0; ovf = 1'b0;

        // reset state
        tick(2);
        check("rst.mx", 32'(mouse_x), 0);
        check("rst.count", 32'(key_count), 0);
        check("rst.kvalid", 32'(kio.key_valid), 0);
        check("rst.ovalid", 32'(kio.osd_valid), 0);
        check("rst.ovf", 32'(overflow), 0);
        do_reset();
        check_all("rst");

        // reset hits a byte in flight
        kms_type = 2'd2; kms_data = 8'h45; kms_level = ~kms_level;
        tick(1);
        reset = 1'b1;
        tick(2);
        check("midrst.count", 32'(key_count), 0);
        check("midrst.kvalid", 32'(kio.key_valid), 0);
        reset = 1'b0;
        tick(8);
        check_all("midrst.after");

        // mouse accumulation
        send(2'd0, 8'h05); send(2'd0, 8'hFE);
        check("mx.sum", 32'(mouse_x), 32'h03);
        send(2'd1, 8'h7F); send(2'd1, 8'h02);
`ifdef KMS_MOUSE_SAT_EN
        check("my.sat", 32'(mouse_y), 32'h7F);
`else
        check("my.wrap", 32'(mouse_y), 32'h81);
`endif
        check_all("mouse");

        // latency: one edge -> exactly one push within 4 clocks
        c0 = int'(key_count);
        kms_type = 2'd2; kms_data = 8'h99; kms_level = ~kms_level;
        lat = 0;
        while (int'(key_count) == c0 && lat < 10) begin tick(1); lat++; end
        check("lat.bound", 32'(lat <= 4), 1);
        tick(6);
        model_byte(2'd2, 8'h99);
        check_all("lat.once");
        // no edge, changing data: nothing happens
        kms_data = 8'h5A; kms_type = 2'd3; tick(4); kms_data = 8'h11; tick(6);
        check_all("noedge");

        // FIFO full then overflow, drain in order
        do_reset();
        for (int i = 0; i < 8; i++) send(2'd2, 8'(8'h10 + i));
        send(2'd2, 8'h18);
        check("full.count", 32'(key_count), 8);
        check("full.ovf", 32'(overflow), 1);
        for (int i = 0; i < 8; i++) pop_one("drain.data");
        check_all("drained");
        kio.key_ready = 1'b1; tick(1); kio.key_ready = 1'b0;
        check_all("pop.empty");

        // push and pop in the same cycle while full
        clr_ovf();
        for (int i = 0; i < 8; i++) send(2'd2, 8'(8'h10 + i));
        send_with(2'd2, 8'h20, 0);
        void'(q.pop_front()); q.push_back(8'h20);
        check("pp.count", 32'(key_count), 8);
        check("pp.ovf", 32'(overflow), 0);
        check_all("pp");
        for (int i = 0; i < 8; i++) pop_one("pp.drain");
        check_all("pp.drained");

        // OSD register
        send(2'd3, 8'h3A);
        check("osd.data", 32'(kio.osd_data), 32'h3A);
        send(2'd3, 8'h3B);
        check("osd.drop", 32'(overflow), 1);
        check_all("osd.drop");
        send_with(2'd3, 8'h3C, 1);
        od = 8'h3C; ov = 1'b1;
        check("osd.ackload", 32'(kio.osd_data), 32'h3C);
        check_all("osd.ackload");
        ack_osd();
        check_all("osd.ack");
        // drop while clearing overflow: set wins
        send(2'd3, 8'h40);
        clr_ovf();
        send_with(2'd3, 8'h41, 2);
        ovf = 1'b1;
        check_all("ovf.setwins");
        clr_ovf();
        check_all("ovf.clr");

        // randomized traffic
        for (int it = 0; it < 250; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            mouse_btn_in = 3'($urandom);
            if (r <= 5) send(2'($urandom), 8'($urandom));
            else if (r <= 7) begin
                if (q.size() != 0) pop_one("rnd.pop");
                else begin kio.key_ready = 1'b1; tick(2); kio.key_ready = 1'b0; end
            end
            else if (r == 8) ack_osd();
            else clr_ovf();
            tick(2);
            check_all("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
